// File: rtl/approx_mult_pkg.sv
// Shared types and default widths for the approximate-multiplier datapath
// and its dot-product accumulation stage.
package approx_mult_pkg;

  localparam int unsigned PROD_W_DEF = 16;
  localparam int unsigned ACC_W_DEF  = 24;
  localparam int unsigned LEN_DEF    = 16;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

endpackage : approx_mult_pkg

// File: rtl/approx_dot_acc_if.sv
// Product input stream and result output stream of the dot-product accumulator.
// master = producer/consumer side, slave = accumulator side.
interface approx_dot_acc_if #(
  parameter int unsigned PROD_W = 16,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned CNT_W  = 5
);

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_ovf
  );

endinterface : approx_dot_acc_if

// File: rtl/approx_dot_acc_acc_add.sv
// Combinational accumulate step: acc + zero-extended product with carry-out.
// APPROX_DOT_ACC_SAT_EN selects saturation to all-ones instead of wrap.
module acc_add #(
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned PROD_W = 16
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum_c,
  output logic              carry_c
);

  logic [ACC_W:0] sum_w;

  assign sum_w   = {1'b0, acc} + (ACC_W+1)'(prod);
  assign carry_c = sum_w[ACC_W];

`ifdef APPROX_DOT_ACC_SAT_EN
  // Once saturated, any further nonzero product carries again, so it stays pinned.
  assign sum_c = sum_w[ACC_W] ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
`else
  assign sum_c = sum_w[ACC_W-1:0];
`endif

endmodule : acc_add

// File: rtl/approx_dot_acc.sv
// Dot-product accumulator: sums LEN products (or fewer, closed by in_last) and
// holds each result on a valid/ready output. Build option: APPROX_DOT_ACC_SAT_EN.
module approx_dot_acc
  import approx_mult_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned LEN    = LEN_DEF,
  parameter int unsigned CNT_W  = $clog2(LEN + 1)
) (
  input logic               clk,
  input logic               rst,
  approx_dot_acc_if.slave   bus
);

  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_acc_q, out_acc_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;

  logic [ACC_W-1:0] sum_c;
  logic             carry_c;
  logic             in_hs_c;
  logic             close_c;

  acc_add #(
    .ACC_W  (ACC_W),
    .PROD_W (PROD_W)
  ) u_acc_add (
    .acc     (acc_q),
    .prod    (bus.in_prod),
    .sum_c   (sum_c),
    .carry_c (carry_c)
  );

  assign in_hs_c = bus.in_valid & in_ready_q;
  // A last flag on the LEN-th product is the same single close.
  assign close_c = in_hs_c & ((cnt_q == CNT_W'(LEN - 1)) | bus.in_last);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_acc_d   = out_acc_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    unique case (state_q)
      ACCUM: begin
        if (close_c) begin
          state_d     = HOLD;
          out_acc_d   = sum_c;
          out_count_d = cnt_q + CNT_W'(1);
          out_ovf_d   = ovf_q | carry_c;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
        end else if (in_hs_c) begin
          acc_d = sum_c;
          cnt_d = cnt_q + CNT_W'(1);
          ovf_d = ovf_q | carry_c;
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = out_acc_q;
  assign bus.out_count = out_count_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule : approx_dot_acc

// File: tb/tb_approx_dot_acc.sv
// Directed bench for approx_dot_acc: a LEN=4/ACC_W=24 instance and a
// LEN=3/ACC_W=17 instance for carry-out behaviour.
module tb_approx_dot_acc;

  logic clk = 1'b0;
  logic rst;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  approx_dot_acc_if #(.PROD_W(16), .ACC_W(24), .CNT_W(3)) if0 ();
  approx_dot_acc_if #(.PROD_W(16), .ACC_W(17), .CNT_W(2)) if1 ();

  approx_dot_acc #(.PROD_W(16), .ACC_W(24), .LEN(4)) dut0 (
    .clk (clk), .rst (rst), .bus (if0)
  );
  approx_dot_acc #(.PROD_W(16), .ACC_W(17), .LEN(3)) dut1 (
    .clk (clk), .rst (rst), .bus (if1)
  );

  // Present one product at a negedge; return at the negedge after the posedge.
  task automatic send0(input logic [15:0] p, input logic last);
    if0.in_valid = 1'b1; if0.in_prod = p; if0.in_last = last;
    @(negedge clk);
    if0.in_valid = 1'b0; if0.in_last = 1'b0;
  endtask

  task automatic send1(input logic [15:0] p, input logic last);
    if1.in_valid = 1'b1; if1.in_prod = p; if1.in_last = last;
    @(negedge clk);
    if1.in_valid = 1'b0; if1.in_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    tests_run++;
    if (if0.out_valid !== 1'b0 || if0.out_acc !== 24'h0 || if0.out_count !== 3'd0 ||
        if0.out_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: valid=%b acc=%h cnt=%0d ovf=%b, want 0/000000/0/0",
               if0.out_valid, if0.out_acc, if0.out_count, if0.out_ovf);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (if0.in_ready !== 1'b1 || if1.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b/%b, want 1/1", if0.in_ready, if1.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    if0.out_ready = 1'b1;
    send0(16'h0100, 1'b0); send0(16'h0200, 1'b0);
    send0(16'h0300, 1'b0); send0(16'h0400, 1'b0);
    tests_run++;
    if (if0.out_valid !== 1'b1 || if0.out_acc !== 24'h000A00 || if0.out_count !== 3'd4 ||
        if0.out_ovf !== 1'b0 || if0.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_result: valid=%b acc=%h cnt=%0d ovf=%b rdy=%b, want 1/000a00/4/0/0",
               if0.out_valid, if0.out_acc, if0.out_count, if0.out_ovf, if0.in_ready);
    end
    @(negedge clk);
    tests_run++;
    if (if0.in_ready !== 1'b1 || if0.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_return: rdy=%b valid=%b, want 1/0", if0.in_ready, if0.out_valid);
    end
  endtask

  task automatic test_last();
    if0.out_ready = 1'b1;
    send0(16'h0010, 1'b0); send0(16'h0020, 1'b1);
    tests_run++;
    if (if0.out_valid !== 1'b1 || if0.out_acc !== 24'h000030 || if0.out_count !== 3'd2) begin
      tests_failed++;
      $display("FAIL last_early: valid=%b acc=%h cnt=%0d, want 1/000030/2",
               if0.out_valid, if0.out_acc, if0.out_count);
    end
    @(negedge clk);
    send0(16'h0005, 1'b1);
    tests_run++;
    if (if0.out_valid !== 1'b1 || if0.out_acc !== 24'h000005 || if0.out_count !== 3'd1) begin
      tests_failed++;
      $display("FAIL last_fresh_group: valid=%b acc=%h cnt=%0d, want 1/000005/1",
               if0.out_valid, if0.out_acc, if0.out_count);
    end
    @(negedge clk);
    // in_last on the LEN-th product: one result, zero products in the next state
    send0(16'h0001, 1'b0); send0(16'h0001, 1'b0);
    send0(16'h0001, 1'b0); send0(16'h0000, 1'b1);
    tests_run++;
    if (if0.out_valid !== 1'b1 || if0.out_acc !== 24'h000003 || if0.out_count !== 3'd4) begin
      tests_failed++;
      $display("FAIL last_on_len: valid=%b acc=%h cnt=%0d, want 1/000003/4",
               if0.out_valid, if0.out_acc, if0.out_count);
    end
    @(negedge clk); @(negedge clk);
    tests_run++;
    if (if0.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL last_no_double: valid=%b, want 0", if0.out_valid);
    end
  endtask

  task automatic test_backpressure();
    if0.out_ready = 1'b0;
    send0(16'h0001, 1'b0); send0(16'h0002, 1'b0);
    send0(16'h0003, 1'b0);
    // Next product waits upstream while the result is held.
    if0.in_valid = 1'b1; if0.in_prod = 16'h0004; if0.in_last = 1'b0;
    @(negedge clk);
    if0.in_prod = 16'h0050; if0.in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (if0.out_valid !== 1'b1 || if0.out_acc !== 24'h00000A || if0.out_count !== 3'd4 ||
          if0.in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: valid=%b acc=%h cnt=%0d rdy=%b, want 1/00000a/4/0",
                 i, if0.out_valid, if0.out_acc, if0.out_count, if0.in_ready);
      end
      @(negedge clk);
    end
    if0.out_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (if0.in_ready !== 1'b1 || if0.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release: rdy=%b valid=%b, want 1/0", if0.in_ready, if0.out_valid);
    end
    @(negedge clk);
    if0.in_valid = 1'b0; if0.in_last = 1'b0;
    tests_run++;
    if (if0.out_valid !== 1'b1 || if0.out_acc !== 24'h000050 || if0.out_count !== 3'd1) begin
      tests_failed++;
      $display("FAIL bp_held_product: valid=%b acc=%h cnt=%0d, want 1/000050/1",
               if0.out_valid, if0.out_acc, if0.out_count);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    logic [16:0] exp_acc;
`ifdef APPROX_DOT_ACC_SAT_EN
    exp_acc = 17'h1FFFF;
`else
    exp_acc = 17'h0FFFD;
`endif
    if1.out_ready = 1'b1;
    send1(16'hFFFF, 1'b0); send1(16'hFFFF, 1'b0); send1(16'hFFFF, 1'b0);
    tests_run++;
    if (if1.out_valid !== 1'b1 || if1.out_acc !== exp_acc || if1.out_count !== 2'd3 ||
        if1.out_ovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_group: valid=%b acc=%h cnt=%0d ovf=%b, want 1/%h/3/1",
               if1.out_valid, if1.out_acc, if1.out_count, if1.out_ovf, exp_acc);
    end
    @(negedge clk);
    send1(16'h0000, 1'b0); send1(16'h0000, 1'b0); send1(16'h0000, 1'b0);
    tests_run++;
    if (if1.out_valid !== 1'b1 || if1.out_acc !== 17'h0 || if1.out_count !== 2'd3 ||
        if1.out_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_group: valid=%b acc=%h cnt=%0d ovf=%b, want 1/00000/3/0",
               if1.out_valid, if1.out_acc, if1.out_count, if1.out_ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_group();
    if0.out_ready = 1'b1;
    send0(16'h0100, 1'b0); send0(16'h0100, 1'b0);
    rst = 1'b1;
    #1;
    tests_run++;
    if (if0.out_valid !== 1'b0 || if0.out_acc !== 24'h0) begin
      tests_failed++;
      $display("FAIL rst_mid: valid=%b acc=%h, want 0/000000", if0.out_valid, if0.out_acc);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send0(16'h0001, 1'b0); send0(16'h0001, 1'b0);
    send0(16'h0001, 1'b0); send0(16'h0001, 1'b0);
    tests_run++;
    if (if0.out_valid !== 1'b1 || if0.out_acc !== 24'h000004 || if0.out_count !== 3'd4) begin
      tests_failed++;
      $display("FAIL rst_mid_fresh: valid=%b acc=%h cnt=%0d, want 1/000004/4",
               if0.out_valid, if0.out_acc, if0.out_count);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_in_hold();
    if0.out_ready = 1'b0;
    send0(16'h0007, 1'b1);
    tests_run++;
    if (if0.out_valid !== 1'b1 || if0.out_acc !== 24'h000007) begin
      tests_failed++;
      $display("FAIL hold_entry: valid=%b acc=%h, want 1/000007", if0.out_valid, if0.out_acc);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b1 || if0.out_acc !== 24'h0) begin
      tests_failed++;
      $display("FAIL rst_hold_async: valid=%b rdy=%b acc=%h, want 0/1/000000",
               if0.out_valid, if0.in_ready, if0.out_acc);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (if0.in_ready !== 1'b1 || if0.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_hold_release: rdy=%b valid=%b, want 1/0", if0.in_ready, if0.out_valid);
    end
  endtask

  initial begin
    if0.in_valid = 1'b0; if0.in_prod = '0; if0.in_last = 1'b0; if0.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.in_prod = '0; if1.in_last = 1'b0; if1.out_ready = 1'b1;
    test_reset();
    test_back_to_back();
    test_last();
    test_backpressure();
    test_overflow();
    test_reset_mid_group();
    test_reset_in_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_approx_dot_acc
